// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared state encoding and word-geometry helpers for the boot ROM loader
//
// Contents:
//   loader_state_t  : IDLE / FETCH / WRITE / DONE
//   bytes_per_word  : bytes in one write word for a given data width
//   lane_width      : bits needed to index a byte lane (never less than 1)

package boot_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // A single-byte word still needs a 1-bit lane register to stay legal.
  function automatic int lane_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/rom_image.sv
// rtl/rom_image.sv - combinational byte ROM holding the boot image
//
// Ports:
//   i_address [31:0] : byte address
//   o_data    [7:0]  : byte at i_address, 0 when i_address >= ROM_DEPTH
//
// The image is a little-endian table of 32-bit words:
//   word 0 = 32'h00000001, word 1 = 32'hDEADBEEF,
//   word 2 = 32'h12345678, word 3 = 32'h0007A120,
//   word k (k >= 4) = {k[7:0], ~k[7:0], 8'hA5, k[7:0]}

module rom_image #(
  parameter int ROM_DEPTH = 224
) (
  input  logic [31:0] i_address,
  output logic [7:0]  o_data
);

  localparam logic [31:0] LP_DEPTH = 32'(ROM_DEPTH);

  logic [7:0]  w_word_idx;
  logic [31:0] w_word;

  assign w_word_idx = i_address[9:2];

  always_comb begin
    w_word = 32'h0;
    case (w_word_idx)
      8'd0:    w_word = 32'h0000_0001;
      8'd1:    w_word = 32'hDEAD_BEEF;
      8'd2:    w_word = 32'h1234_5678;
      8'd3:    w_word = 32'h0007_A120;
      default: w_word = {w_word_idx, ~w_word_idx, 8'hA5, w_word_idx};
    endcase
  end

  assign o_data = (i_address < LP_DEPTH) ? w_word[{i_address[1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: rtl/boot_rom_loader.sv
// rtl/boot_rom_loader.sv - copies a byte ROM image into word-wide memory writes
//
// Ports:
//   clock         : single clock, rising edge
//   reset         : synchronous, active-high
//   start         : begin a copy (honoured only in IDLE or DONE)
//   rom_address   : byte address presented to the ROM image
//   rom_byte      : combinational ROM data for rom_address
//   mem_address   : byte address of the current write word
//   mem_data      : assembled little-endian write word
//   mem_valid     : write request (held in WRITE)
//   mem_ready     : write accept
//   busy          : high in FETCH or WRITE
//   done          : high in DONE
//   words_written : completed write handshakes since the last start
//   checksum_ok   : image checksum result
//
// Build option BOOT_CHECKSUM_EN: keeps a modulo-256 sum of every latched
// byte; checksum_ok is 1 only in DONE when the sum matches EXPECTED_CHECKSUM.
// Without it checksum_ok is tied to 1.

module boot_rom_loader
  import boot_loader_pkg::*;
#(
  parameter int          DATA_WIDTH        = 32,
  parameter int          ROM_DEPTH         = 224,
  parameter logic [31:0] BASE_ADDR         = 32'd0,
  parameter logic [7:0]  EXPECTED_CHECKSUM = 8'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [31:0]           rom_address,
  input  logic [7:0]            rom_byte,
  output logic [31:0]           mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           words_written,
  output logic                  checksum_ok
);

  localparam int                BYTES        = bytes_per_word(DATA_WIDTH);
  localparam int                LANE_W       = lane_width(BYTES);
  localparam logic [31:0]       LP_DEPTH     = 32'(ROM_DEPTH);
  localparam logic [31:0]       LP_BYTES     = 32'(BYTES);
  localparam logic [LANE_W-1:0] LP_LAST_LANE = LANE_W'(BYTES - 1);

  loader_state_t r_state;
  loader_state_t w_next_state;

  logic [31:0]           r_byte_count;
  logic [LANE_W-1:0]     r_lane;
  logic [31:0]           r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [31:0]           r_words_written;

  logic w_word_full;
  logic w_image_end;
  logic w_start_copy;
  logic w_handshake;

  // The byte being latched this cycle closes the word if it fills the top
  // lane or is the last byte of the image.
  assign w_word_full  = (r_lane == LP_LAST_LANE) || (r_byte_count == LP_DEPTH - 32'd1);
  assign w_image_end  = (r_byte_count == LP_DEPTH);
  assign w_start_copy = ((r_state == IDLE) || (r_state == DONE)) && start;
  assign w_handshake  = (r_state == WRITE) && mem_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (w_word_full) w_next_state = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        if (mem_ready) w_next_state = w_image_end ? DONE : FETCH;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_next_state = FETCH;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath. mem_data starts every word at zero, so lanes left unfilled by
  // a short final word read back as zero without extra masking.
  always_ff @(posedge clock) begin
    if (reset || w_start_copy) begin
      r_byte_count    <= 32'd0;
      r_lane          <= '0;
      r_mem_address   <= BASE_ADDR;
      r_mem_data      <= '0;
      r_words_written <= 32'd0;
    end else if (r_state == FETCH) begin
      r_mem_data[{r_lane, 3'b000} +: 8] <= rom_byte;
      r_byte_count                      <= r_byte_count + 32'd1;
      r_lane                            <= w_word_full ? '0 : r_lane + LANE_W'(1);
    end else if (w_handshake) begin
      r_words_written <= r_words_written + 32'd1;
      r_mem_address   <= r_mem_address + LP_BYTES;
      if (!w_image_end) r_mem_data <= '0;
    end
  end

  assign rom_address   = r_byte_count;
  assign mem_address   = r_mem_address;
  assign mem_data      = r_mem_data;
  assign words_written = r_words_written;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] r_sum;

  always_ff @(posedge clock) begin
    if (reset || w_start_copy) begin
      r_sum <= 8'd0;
    end else if (r_state == FETCH) begin
      r_sum <= r_sum + rom_byte;
    end
  end

  assign checksum_ok = (r_state == DONE) && (r_sum == EXPECTED_CHECKSUM);
`else
  logic [7:0] w_unused_expected_checksum;

  assign w_unused_expected_checksum = EXPECTED_CHECKSUM;
  assign checksum_ok                = 1'b1;
`endif

endmodule

// File: tb/tb_boot_rom_loader.sv
// tb/tb_boot_rom_loader.sv - self-checking bench for boot_rom_loader with rom_image

module tb_boot_rom_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

`ifdef BOOT_CHECKSUM_EN
  localparam logic EXP_CK_DEFAULT = 1'b0;
`else
  localparam logic EXP_CK_DEFAULT = 1'b1;
`endif

  logic clk;
  logic reset;
  logic start;
  logic rdy_a;

  int n_cmp = 0;
  int n_bad = 0;
  int at_a, at_p, at_w;

  wr_t q_a[$];
  wr_t q_p[$];
  wr_t q_w[$];

  // main instance: defaults
  logic [31:0] ra_a, ma_a, md_a, ww_a;
  logic [7:0]  rb_a;
  logic        mv_a, busy_a, done_a, ck_a;
  // partial instance: ROM_DEPTH = 6
  logic [31:0] ra_p, ma_p, md_p, ww_p;
  logic [7:0]  rb_p;
  logic        mv_p, busy_p, done_p, ck_p;
  // byte-wide instance: DATA_WIDTH = 8
  logic [31:0] ra_w, ma_w, ww_w;
  logic [7:0]  rb_w, md_w;
  logic        mv_w, busy_w, done_w, ck_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rom_image #(.ROM_DEPTH(224)) u_rom_a (.i_address(ra_a), .o_data(rb_a));
  boot_rom_loader u_dut_a (
    .clock(clk), .reset(reset), .start(start), .rom_address(ra_a), .rom_byte(rb_a),
    .mem_address(ma_a), .mem_data(md_a), .mem_valid(mv_a), .mem_ready(rdy_a),
    .busy(busy_a), .done(done_a), .words_written(ww_a), .checksum_ok(ck_a));

  rom_image #(.ROM_DEPTH(6)) u_rom_p (.i_address(ra_p), .o_data(rb_p));
  boot_rom_loader #(.ROM_DEPTH(6)) u_dut_p (
    .clock(clk), .reset(reset), .start(start), .rom_address(ra_p), .rom_byte(rb_p),
    .mem_address(ma_p), .mem_data(md_p), .mem_valid(mv_p), .mem_ready(1'b1),
    .busy(busy_p), .done(done_p), .words_written(ww_p), .checksum_ok(ck_p));

  rom_image #(.ROM_DEPTH(224)) u_rom_w (.i_address(ra_w), .o_data(rb_w));
  boot_rom_loader #(.DATA_WIDTH(8)) u_dut_w (
    .clock(clk), .reset(reset), .start(start), .rom_address(ra_w), .rom_byte(rb_w),
    .mem_address(ma_w), .mem_data(md_w), .mem_valid(mv_w), .mem_ready(1'b1),
    .busy(busy_w), .done(done_w), .words_written(ww_w), .checksum_ok(ck_w));

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] ra_c1, ma_c1, md_c1, ww_c1, ra_c0, ma_c0, md_c0, ww_c0;
  logic [7:0]  rb_c1, rb_c0;
  logic        mv_c1, busy_c1, done_c1, ck_c1, mv_c0, busy_c0, done_c0, ck_c0;

  // True image sum is 8'h63; c0 is deliberately off by one.
  rom_image #(.ROM_DEPTH(224)) u_rom_c1 (.i_address(ra_c1), .o_data(rb_c1));
  boot_rom_loader #(.EXPECTED_CHECKSUM(8'h63)) u_dut_c1 (
    .clock(clk), .reset(reset), .start(start), .rom_address(ra_c1), .rom_byte(rb_c1),
    .mem_address(ma_c1), .mem_data(md_c1), .mem_valid(mv_c1), .mem_ready(1'b1),
    .busy(busy_c1), .done(done_c1), .words_written(ww_c1), .checksum_ok(ck_c1));

  rom_image #(.ROM_DEPTH(224)) u_rom_c0 (.i_address(ra_c0), .o_data(rb_c0));
  boot_rom_loader #(.EXPECTED_CHECKSUM(8'h64)) u_dut_c0 (
    .clock(clk), .reset(reset), .start(start), .rom_address(ra_c0), .rom_byte(rb_c0),
    .mem_address(ma_c0), .mem_data(md_c0), .mem_valid(mv_c0), .mem_ready(1'b1),
    .busy(busy_c0), .done(done_c0), .words_written(ww_c0), .checksum_ok(ck_c0));
`endif

  function automatic wr_t mk(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  // Independent description of the boot image bytes.
  function automatic logic [7:0] model_byte(input int a);
    logic [31:0] w;
    logic [7:0]  k;
    k = 8'(a / 4);
    case (a / 4)
      0:       w = 32'h0000_0001;
      1:       w = 32'hDEAD_BEEF;
      2:       w = 32'h1234_5678;
      3:       w = 32'h0007_A120;
      default: w = {k, ~k, 8'hA5, k};
    endcase
    return w[8 * (a % 4) +: 8];
  endfunction

  // Write handshakes are captured mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (mv_a && rdy_a) q_a.push_back(mk(ma_a, md_a));
    if (mv_p)          q_p.push_back(mk(ma_p, md_p));
    if (mv_w)          q_w.push_back(mk(ma_w, {24'h0, md_w}));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // start is high in cycle 0; cycle k is the interval after clock edge k.
  task automatic run_copy(input int stall_at, input int stall_len, input int busy_start_at);
    q_a.delete();
    q_p.delete();
    q_w.delete();
    at_a  = -1;
    at_p  = -1;
    at_w  = -1;
    start = 1'b1;
    rdy_a = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      tick();
      start = (k == busy_start_at);
      rdy_a = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
      if (stall_len > 0 && k >= stall_at && k <= stall_at + stall_len) begin
        chk("stall_mem_valid", {31'h0, mv_a}, 32'd1);
        chk("stall_mem_address", ma_a, 32'd4);
        chk("stall_mem_data", md_a, 32'hDEAD_BEEF);
      end
      if (k == busy_start_at) chk("busy_when_start", {31'h0, busy_a}, 32'd1);
      if (done_a && at_a < 0) at_a = k;
      if (done_p && at_p < 0) at_p = k;
      if (done_w && at_w < 0) at_w = k;
      if (at_a >= 0 && at_p >= 0 && at_w >= 0) break;
    end
    start = 1'b0;
    rdy_a = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0,  32'd0,   32'h0000_0001};
    vecs[1] = '{1,  32'd4,   32'hDEAD_BEEF};
    vecs[2] = '{2,  32'd8,   32'h1234_5678};
    vecs[3] = '{3,  32'd12,  32'h0007_A120};
    vecs[4] = '{4,  32'd16,  32'h04FB_A504};
    vecs[5] = '{55, 32'd220, 32'h37C8_A537};

    reset = 1'b1;
    start = 1'b0;
    rdy_a = 1'b1;
    tick();
    tick();

    chk("reset_rom_address", ra_a, 32'd0);
    chk("reset_mem_address", ma_a, 32'd0);
    chk("reset_mem_data", md_a, 32'd0);
    chk("reset_mem_valid", {31'h0, mv_a}, 32'd0);
    chk("reset_busy", {31'h0, busy_a}, 32'd0);
    chk("reset_done", {31'h0, done_a}, 32'd0);
    chk("reset_words_written", ww_a, 32'd0);
    chk("reset_checksum_ok", {31'h0, ck_a}, {31'h0, EXP_CK_DEFAULT});

    reset = 1'b0;
    tick();

    // Full copy on all instances.
    run_copy(0, 0, 0);
    chk("full_done_cycle", at_a, 32'd281);
    chk("full_word_count", q_a.size(), 32'd56);
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].idx < q_a.size()) begin
        chk($sformatf("full_word%0d_addr", vecs[i].idx), q_a[vecs[i].idx].addr, vecs[i].addr);
        chk($sformatf("full_word%0d_data", vecs[i].idx), q_a[vecs[i].idx].data, vecs[i].data);
      end else begin
        chk($sformatf("full_word%0d_present", vecs[i].idx), q_a.size(), vecs[i].idx + 1);
      end
    end
    chk("full_words_written", ww_a, 32'd56);
    chk("full_final_mem_address", ma_a, 32'd224);
    chk("full_checksum_ok", {31'h0, ck_a}, {31'h0, EXP_CK_DEFAULT});

    chk("partial_done_cycle", at_p, 32'd9);
    chk("partial_word_count", q_p.size(), 32'd2);
    if (q_p.size() >= 2) begin
      chk("partial_word0_data", q_p[0].data, 32'h0000_0001);
      chk("partial_word1_addr", q_p[1].addr, 32'd4);
      chk("partial_word1_data", q_p[1].data, 32'h0000_BEEF);
    end
    chk("partial_words_written", ww_p, 32'd2);

    chk("w8_done_cycle", at_w, 32'd449);
    chk("w8_write_count", q_w.size(), 32'd224);
    for (int i = 0; i < 224 && i < q_w.size(); i++) begin
      chk($sformatf("w8_addr%0d", i), q_w[i].addr, i);
      chk($sformatf("w8_data%0d", i), q_w[i].data, {24'h0, model_byte(i)});
    end
    chk("w8_words_written", ww_w, 32'd224);

`ifdef BOOT_CHECKSUM_EN
    chk("checksum_match_ok", {31'h0, ck_c1}, 32'd1);
    chk("checksum_off_by_one_ok", {31'h0, ck_c0}, 32'd0);
`endif

    // Restart from DONE with 3 stalled cycles on word 1 and a start while busy.
    run_copy(10, 3, 100);
    chk("stall_done_cycle", at_a, 32'd284);
    chk("stall_word_count", q_a.size(), 32'd56);
    if (q_a.size() >= 2) chk("stall_word1_data", q_a[1].data, 32'hDEAD_BEEF);
    chk("stall_words_written", ww_a, 32'd56);
    chk("w8_restart_done_cycle", at_w, 32'd449);
    chk("w8_restart_write_count", q_w.size(), 32'd224);
    if (q_w.size() == 224) chk("w8_restart_last_addr", q_w[223].addr, 32'd223);
    chk("w8_restart_done", {31'h0, done_w}, 32'd1);

    // Reset while word 10 is being offered.
    start = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      tick();
      start = 1'b0;
    end
    chk("midreset_pre_valid", {31'h0, mv_a}, 32'd1);
    chk("midreset_pre_addr", ma_a, 32'd40);
    reset = 1'b1;
    tick();
    chk("midreset_mem_valid", {31'h0, mv_a}, 32'd0);
    chk("midreset_busy", {31'h0, busy_a}, 32'd0);
    chk("midreset_done", {31'h0, done_a}, 32'd0);
    chk("midreset_words_written", ww_a, 32'd0);
    chk("midreset_rom_address", ra_a, 32'd0);
    chk("midreset_mem_address", ma_a, 32'd0);
    chk("midreset_mem_data", md_a, 32'd0);
    start = 1'b1;
    tick();
    chk("reset_over_start_busy", {31'h0, busy_a}, 32'd0);
    reset = 1'b0;
    run_copy(0, 0, 0);
    chk("after_reset_done_cycle", at_a, 32'd281);
    chk("after_reset_word_count", q_a.size(), 32'd56);
    if (q_a.size() >= 4) chk("after_reset_word3_data", q_a[3].data, 32'h0007_A120);
    chk("after_reset_words_written", ww_a, 32'd56);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required earlier completion");
    $fatal(1);
  end

endmodule

// File: doc/boot_rom_loader.md
BOOT_ROM_LOADER -- requirements
Module: boot_rom_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: write word width in bits; multiple of 8, at least 8.
REQ-002 SHALL have parameter ROM_DEPTH, default 224: number of ROM bytes to copy; at least 1.
REQ-003 SHALL have parameter BASE_ADDR, default 32'd0: first memory write address.
REQ-004 SHALL have parameter EXPECTED_CHECKSUM, default 8'd0: reference sum, used only when BOOT_CHECKSUM_EN is defined.
REQ-005 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: begin a copy; sampled only in IDLE or DONE.
REQ-008 SHALL have port rom_address, output, 32 bits: byte address presented to the ROM image.
REQ-009 SHALL have port rom_byte, input, 8 bits: combinational ROM data for rom_address, in the same cycle.
REQ-010 SHALL have port mem_address, output, 32 bits: byte address of the current write word.
REQ-011 SHALL have port mem_data, output, DATA_WIDTH bits: assembled write word.
REQ-012 SHALL have port mem_valid, output, 1 bit: write request.
REQ-013 SHALL have port mem_ready, input, 1 bit: write accept.
REQ-014 SHALL have port busy, output, 1 bit: high in FETCH or WRITE.
REQ-015 SHALL have port done, output, 1 bit: high in DONE.
REQ-016 SHALL have port words_written, output, 32 bits: count of completed write handshakes.
REQ-017 SHALL have port checksum_ok, output, 1 bit: checksum result (see Configuration).

Function
REQ-018 SHALL implement states IDLE, FETCH, WRITE and DONE, with BYTES = DATA_WIDTH/8.
REQ-019 SHALL go from IDLE or DONE to FETCH when start=1; this clears byte_count, the lane index, words_written and the checksum, and sets mem_address=BASE_ADDR.
REQ-020 SHALL, in FETCH, drive rom_address=byte_count every cycle.
REQ-021 SHALL, in FETCH, latch rom_byte into lane (byte_count mod BYTES) of mem_data, little-endian, and increment byte_count.
REQ-022 SHALL go from FETCH to WRITE once BYTES bytes have been latched, or after the byte at ROM_DEPTH-1 is latched.
REQ-023 SHALL zero the lanes of a partial final word that were not filled.
REQ-024 SHALL hold mem_valid=1 in WRITE; mem_data and mem_address SHALL stay stable until mem_ready=1.
REQ-025 SHALL, on handshake (mem_valid and mem_ready both 1): increment words_written; add BYTES to mem_address; go to DONE if byte_count==ROM_DEPTH, else to FETCH with mem_data cleared.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL hold done=1 in DONE until start=1 restarts the copy.
REQ-028 SHALL make every output a registered or state-decoded signal, with no combinational path from rom_byte or mem_ready to any output.
REQ-029 SHALL take exactly BYTES+1 cycles per full word with mem_ready held at 1; each cycle with mem_ready=0 in WRITE adds one cycle.

Reset
REQ-030 SHALL, when reset=1 at a clock edge, enter IDLE regardless of state, including mid-copy with mem_valid=1; an in-flight word is dropped.
REQ-031 SHALL set these reset values: rom_address=0, mem_address=BASE_ADDR, mem_data=0, mem_valid=0, busy=0, done=0, words_written=0, checksum_ok=0 (1 without the macro).
REQ-032 SHALL give reset priority over start at the same edge.

Configuration
REQ-033 SHALL, with BOOT_CHECKSUM_EN defined, keep an 8-bit modulo-256 sum of every latched byte and drive checksum_ok=1 only in DONE when the sum equals EXPECTED_CHECKSUM, 0 otherwise.
REQ-034 SHALL, without BOOT_CHECKSUM_EN, include no checksum logic and tie checksum_ok to 1'b1; the port list SHALL be identical in both builds.

Structure
REQ-035 SHALL place the state enumeration and the BYTES-per-word constant function in shared package boot_loader_pkg.
REQ-036 SHALL use one sub-module, rom_image: a combinational byte ROM with a ROM_DEPTH parameter that returns 0 for out-of-range addresses, instantiated beside the loader in the top-level test harness, not inside the loader.

Verification
REQ-037 SHALL cover a full image copy: defaults, mem_ready=1, start pulse at cycle 0 -> word0 32'h00000001 at address 0, word3 32'h0007A120 at address 12, 56 words total, done=1 at cycle 281.
REQ-038 SHALL cover backpressure: mem_ready=0 for 3 cycles on word 1 -> mem_valid held, mem_data and mem_address=4 stable, done delayed by exactly 3 cycles.
REQ-039 SHALL cover a partial final word: ROM_DEPTH=6 -> second word at address 4 equals {16'h0000, byte5, byte4}; words_written=2.
REQ-040 SHALL cover reset mid-copy: reset=1 while in WRITE on word 10 -> next cycle IDLE, mem_valid=0, words_written=0; a following start copies the full image again.
REQ-041 SHALL cover the checksum build: BOOT_CHECKSUM_EN with EXPECTED_CHECKSUM equal to the true sum -> checksum_ok=1 in DONE; with EXPECTED_CHECKSUM off by one -> checksum_ok=0.
REQ-042 SHALL cover restart and width: start in DONE with DATA_WIDTH=8 -> 224 single-byte writes, addresses 0..223, and done re-asserted.
